// File: rtl/mmu_pkg.sv
// Shared types and default geometry for the systolic-array sequencer.
package mmu_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_ACC_WIDTH = 40;
    localparam int DEF_DEPTH     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WT,
        WT_SETTLE,
        FEED,
        DRAIN,
        RESULT
    } state_t;

    // Lane idx of a packed vector at the default geometry.
    function automatic logic [DEF_BIT_WIDTH-1:0] lane_slice(
        input logic [DEF_BIT_WIDTH*DEF_DEPTH-1:0] vec,
        input int                                 idx
    );
        return vec[idx*DEF_BIT_WIDTH +: DEF_BIT_WIDTH];
    endfunction

endpackage

// File: rtl/mmu_sequencer_if.sv
// Upstream weight/data streams and downstream result handshake of the sequencer.
interface mmu_sequencer_if
    import mmu_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
);
    logic [BIT_WIDTH*DEPTH-1:0] wt_col;
    logic                       wt_valid;
    logic                       wt_ready;
    logic [BIT_WIDTH*DEPTH-1:0] data_vec;
    logic                       data_valid;
    logic                       data_ready;
    logic [ACC_WIDTH*DEPTH-1:0] res_out;
    logic                       res_valid;
    logic                       res_ready;

    modport master (
        output wt_col, wt_valid, data_vec, data_valid, res_ready,
        input  wt_ready, data_ready, res_out, res_valid
    );

    modport slave (
        input  wt_col, wt_valid, data_vec, data_valid, res_ready,
        output wt_ready, data_ready, res_out, res_valid
    );
endinterface

// File: rtl/mmu_sequencer_skew_line.sv
// One lane of the data skewer: DELAY cycles of delay plus the output register.
module skew_line #(
    parameter int BIT_WIDTH = 16,
    parameter int DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0] dout
);
    logic [BIT_WIDTH-1:0] taps [DELAY+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= DELAY; k++) taps[k] <= '0;
        end else begin
            taps[0] <= din;
            for (int k = 1; k <= DELAY; k++) taps[k] <= taps[k-1];
        end
    end

    assign dout = taps[DELAY];
endmodule

// File: rtl/mmu_sequencer.sv
// Sequencer for a weight-stationary DEPTHxDEPTH systolic array: loads weight columns,
// feeds diagonally skewed data, waits for the drain and captures the bottom-row result.
//
// state     | meaning
// IDLE      | waiting for start
// LOAD_WT   | accepting DEPTH weight columns, one shift per accepted column
// WT_SETTLE | one quiet cycle after the last column
// FEED      | DEPTH back-to-back data beats into the skewer
// DRAIN     | skewer empties and partial sums reach the bottom row
// RESULT    | result held until downstream takes it
module mmu_sequencer
    import mmu_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int DRAIN_CYCLES = 2*DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       reuse_wt,
    mmu_sequencer_if.slave             bus,
    output logic                       mmu_control,
    output logic [BIT_WIDTH*DEPTH-1:0] mmu_wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0] mmu_data_arr,
    input  logic [ACC_WIDTH*DEPTH-1:0] pe_out,
    output logic                       busy,
    output logic                       wt_loaded,
    output logic                       err_underrun
);
    localparam int CNT_W = $clog2(DEPTH + DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LANE_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DEPTH - 1 + DRAIN_CYCLES);

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic                       wt_accept, feed_beat, capture, res_take;
    logic                       clr_err, set_loaded, clr_loaded;
    logic [BIT_WIDTH*DEPTH-1:0] push;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wt_accept  = 1'b0;
        feed_beat  = 1'b0;
        capture    = 1'b0;
        res_take   = 1'b0;
        clr_err    = 1'b0;
        set_loaded = 1'b0;
        clr_loaded = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_err = 1'b1;
                    cnt_nxt = LANE_LAST;
                    if (reuse_wt && wt_loaded) begin
                        state_nxt = FEED;
                    end else begin
                        state_nxt  = LOAD_WT;
                        clr_loaded = 1'b1;
                    end
                end
            end
            LOAD_WT: begin
                if (bus.wt_valid) begin
                    wt_accept = 1'b1;
                    if (cnt == '0) state_nxt = WT_SETTLE;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            WT_SETTLE: begin
                set_loaded = 1'b1;
                cnt_nxt    = LANE_LAST;
                state_nxt  = FEED;
            end
            FEED: begin
                feed_beat = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESULT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A missing beat still advances the skew so later rows keep their diagonal slot.
    assign push = (feed_beat && bus.data_valid) ? bus.data_vec : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            busy           <= 1'b0;
            bus.wt_ready   <= 1'b0;
            bus.data_ready <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_out    <= '0;
            mmu_control    <= 1'b0;
            mmu_wt_arr     <= '0;
            wt_loaded      <= 1'b0;
            err_underrun   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            busy           <= (state_nxt != IDLE);
            bus.wt_ready   <= (state_nxt == LOAD_WT);
            bus.data_ready <= (state_nxt == FEED);
            mmu_control    <= wt_accept;
            mmu_wt_arr     <= wt_accept ? bus.wt_col : '0;
            if (clr_loaded)      wt_loaded <= 1'b0;
            else if (set_loaded) wt_loaded <= 1'b1;
            if (clr_err)                           err_underrun <= 1'b0;
            else if (feed_beat && !bus.data_valid) err_underrun <= 1'b1;
            if (capture) begin
                bus.res_out   <= pe_out;
                bus.res_valid <= 1'b1;
            end else if (res_take) begin
                bus.res_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        skew_line #(
            .BIT_WIDTH (BIT_WIDTH),
            .DELAY     (i)
        ) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (push[i*BIT_WIDTH +: BIT_WIDTH]),
            .dout (mmu_data_arr[i*BIT_WIDTH +: BIT_WIDTH])
        );
    end
endmodule
